// File: rtl/src_ctrl_pkg.sv
// src_ctrl_pkg: opcodes, phase encoding, strobe vector and per-opcode sequence length
package src_ctrl_pkg;
  localparam int STEP_W = 3;
  typedef enum logic [1:0] {PH_RESET, PH_FETCH, PH_EXEC, PH_HALT} phase_t;
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  typedef struct packed {
    logic       run;
    logic       clear_out;
    logic [4:0] control;
    logic       inc_pc;
    logic       read;
    logic       write;
    logic       pc_out;
    logic       mdr_out;
    logic       zhi_out;
    logic       zlo_out;
    logic       hi_out;
    logic       lo_out;
    logic       c_out;
    logic       inport_out;
    logic       pc_in;
    logic       mdr_in;
    logic       mar_in;
    logic       ir_in;
    logic       y_in;
    logic       zhi_in;
    logic       zlo_in;
    logic       hi_in;
    logic       lo_in;
    logic       inport_in;
    logic       outport_in;
    logic       con_in;
    logic       g_ra;
    logic       g_rb;
    logic       g_rc;
    logic       r_in;
    logic       r_out;
    logic       ba_out;
  } strobes_t;
  function automatic logic [STEP_W-1:0] last_step(input logic [4:0] op);
    case (op)
      OP_LD, OP_ST: return 3'd7;
      OP_MUL, OP_DIV, OP_BR: return 3'd6;
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
      OP_ADDI, OP_ANDI, OP_ORI: return 3'd5;
      OP_NEG, OP_NOT, OP_JAL: return 3'd4;
      default: return 3'd3;
    endcase
  endfunction
endpackage

// File: rtl/src_ctrl_decode.sv
// src_ctrl_decode: combinational map of (phase, step, opcode, ConFF) to datapath strobes
module src_ctrl_decode import src_ctrl_pkg::*; #(
  parameter logic [4:0] ADD_CODE = 5'b00011
) (
  input  phase_t            phase,
  input  logic [STEP_W-1:0] step,
  input  logic [4:0]        opcode,
  input  logic              con_ff,
  output strobes_t          s
);
  logic [4:0] imm_code;
  logic is_ld, is_ldi, is_st;
  assign imm_code = opcode == OP_ADDI ? OP_ADD : opcode == OP_ANDI ? OP_AND : OP_OR;
  assign is_ld = opcode == OP_LD;
  assign is_ldi = opcode == OP_LDI;
  assign is_st = opcode == OP_ST;
  always_comb begin
    s = '0;
    s.clear_out = phase == PH_RESET;
    s.run = phase == PH_FETCH || phase == PH_EXEC;
    s.inport_in = phase != PH_RESET;
    if (phase == PH_FETCH) begin
      case (step)
        3'd0: begin s.pc_out = 1'b1; s.mar_in = 1'b1; s.inc_pc = 1'b1; end
        3'd1: begin s.read = 1'b1; s.mdr_in = 1'b1; end
        3'd2: begin s.mdr_out = 1'b1; s.ir_in = 1'b1; end
        default: ;
      endcase
    end else if (phase == PH_EXEC) begin
      case (opcode)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
        OP_ADDI, OP_ANDI, OP_ORI:
          case (step)
            3'd3: begin s.g_rb = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1; end
            3'd4: begin
              s.zlo_in = 1'b1;
              if (opcode == OP_ADDI || opcode == OP_ANDI || opcode == OP_ORI) begin
                s.c_out = 1'b1;
                s.control = imm_code;
              end else begin
                s.g_rc = 1'b1;
                s.r_out = 1'b1;
                s.control = opcode;
              end
            end
            3'd5: begin s.zlo_out = 1'b1; s.g_ra = 1'b1; s.r_in = 1'b1; end
            default: ;
          endcase
        OP_NEG, OP_NOT:
          case (step)
            3'd3: begin s.g_rb = 1'b1; s.r_out = 1'b1; s.zlo_in = 1'b1; s.control = opcode; end
            3'd4: begin s.zlo_out = 1'b1; s.g_ra = 1'b1; s.r_in = 1'b1; end
            default: ;
          endcase
        OP_MUL, OP_DIV:
          case (step)
            3'd3: begin s.g_ra = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1; end
            3'd4: begin
              s.g_rb = 1'b1; s.r_out = 1'b1; s.zhi_in = 1'b1; s.zlo_in = 1'b1; s.control = opcode;
            end
            3'd5: begin s.zlo_out = 1'b1; s.lo_in = 1'b1; end
            3'd6: begin s.zhi_out = 1'b1; s.hi_in = 1'b1; end
            default: ;
          endcase
        // ld, ldi and st share the base+offset address computation through T4
        OP_LD, OP_LDI, OP_ST:
          case (step)
            3'd3: begin s.g_rb = 1'b1; s.r_out = 1'b1; s.ba_out = 1'b1; s.y_in = 1'b1; end
            3'd4: begin s.c_out = 1'b1; s.zlo_in = 1'b1; s.control = ADD_CODE; end
            3'd5: begin s.zlo_out = 1'b1; s.g_ra = is_ldi; s.r_in = is_ldi; s.mar_in = !is_ldi; end
            3'd6: begin s.mdr_in = 1'b1; s.read = is_ld; s.g_ra = is_st; s.r_out = is_st; end
            3'd7: begin s.mdr_out = is_ld; s.g_ra = is_ld; s.r_in = is_ld; s.write = is_st; end
            default: ;
          endcase
        OP_BR:
          case (step)
            3'd3: begin s.g_ra = 1'b1; s.r_out = 1'b1; s.con_in = 1'b1; end
            3'd4: begin s.pc_out = 1'b1; s.y_in = 1'b1; end
            3'd5: begin s.c_out = 1'b1; s.zlo_in = 1'b1; s.control = ADD_CODE; end
            3'd6: begin s.zlo_out = con_ff; s.pc_in = con_ff; end
            default: ;
          endcase
        OP_JR: if (step == 3'd3) begin s.g_ra = 1'b1; s.r_out = 1'b1; s.pc_in = 1'b1; end
        OP_JAL:
          case (step)
            3'd3: begin s.pc_out = 1'b1; s.g_rb = 1'b1; s.r_in = 1'b1; end
            3'd4: begin s.g_ra = 1'b1; s.r_out = 1'b1; s.pc_in = 1'b1; end
            default: ;
          endcase
        OP_IN: if (step == 3'd3) begin s.inport_out = 1'b1; s.g_ra = 1'b1; s.r_in = 1'b1; end
        OP_OUT: if (step == 3'd3) begin s.g_ra = 1'b1; s.r_out = 1'b1; s.outport_in = 1'b1; end
        OP_MFHI: if (step == 3'd3) begin s.hi_out = 1'b1; s.g_ra = 1'b1; s.r_in = 1'b1; end
        OP_MFLO: if (step == 3'd3) begin s.lo_out = 1'b1; s.g_ra = 1'b1; s.r_in = 1'b1; end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/src_control_unit.sv
// src_control_unit: hardwired Moore sequencer driving the Mini SRC datapath strobes
module src_control_unit import src_ctrl_pkg::*; #(
  parameter int         MEM_WAIT = 1,
  parameter logic [4:0] ADD_CODE = 5'b00011
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        ConFF_Out,
  input  logic        Stop,
  output logic        Run,
  output logic        Clear_Out,
  output logic [4:0]  CONTROL,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        PC_Out,
  output logic        MDR_Out,
  output logic        ZHI_Out,
  output logic        ZLO_Out,
  output logic        HI_Out,
  output logic        LO_Out,
  output logic        C_Out,
  output logic        InPort_Out,
  output logic        PC_In,
  output logic        MDR_In,
  output logic        MAR_In,
  output logic        IR_In,
  output logic        Y_In,
  output logic        ZHI_In,
  output logic        ZLO_In,
  output logic        HI_In,
  output logic        LO_In,
  output logic        InPort_In,
  output logic        OutPort_In,
  output logic        Con_In,
  output logic        G_RA,
  output logic        G_RB,
  output logic        G_RC,
  output logic        R_In,
  output logic        R_Out,
  output logic        BA_Out
);
  localparam int WW = MEM_WAIT > 1 ? $clog2(MEM_WAIT) : 1;
  phase_t phase;
  logic [STEP_W-1:0] step;
  logic [WW-1:0] wait_cnt;
  logic [4:0] opcode;
  logic hold, last, unused_ir;
  strobes_t s;
  assign opcode = IR[31:27];
  assign unused_ir = ^IR[26:0];
  // Read/Write only appear in memory steps, so they double as the wait-state trigger
  assign hold = (s.read | s.write) && wait_cnt != WW'(MEM_WAIT - 1);
  assign last = step == last_step(opcode);
  src_ctrl_decode #(.ADD_CODE(ADD_CODE)) u_decode (
    .phase(phase),
    .step(step),
    .opcode(opcode),
    .con_ff(ConFF_Out),
    .s(s)
  );
  always_ff @(posedge Clock)
    if (!Clear) begin
      phase <= PH_RESET;
      step <= '0;
      wait_cnt <= '0;
    end else if (hold)
      wait_cnt <= wait_cnt + 1'b1;
    else begin
      wait_cnt <= '0;
      case (phase)
        PH_RESET: begin phase <= PH_FETCH; step <= '0; end
        PH_FETCH: begin phase <= step == 3'd2 ? PH_EXEC : PH_FETCH; step <= step + 1'b1; end
        PH_EXEC: begin
          phase <= !last ? PH_EXEC : (opcode == OP_HALT || Stop) ? PH_HALT : PH_FETCH;
          step <= last ? '0 : step + 1'b1;
        end
        default: ;
      endcase
    end
  assign {Run, Clear_Out, CONTROL, IncPC, Read, Write, PC_Out, MDR_Out, ZHI_Out, ZLO_Out,
          HI_Out, LO_Out, C_Out, InPort_Out, PC_In, MDR_In, MAR_In, IR_In, Y_In, ZHI_In,
          ZLO_In, HI_In, LO_In, InPort_In, OutPort_In, Con_In, G_RA, G_RB, G_RC, R_In,
          R_Out, BA_Out} = s;
endmodule

// File: doc/src_control_unit.md
Name: src_control_unit

Overview:
- Hardwired Moore control sequencer for the single-bus Mini SRC datapath.
- Sits directly upstream of the datapath and drives every datapath strobe, including register selects, bus-out enables, latch enables, the ALU CONTROL code and memory Read/Write.
- Consumes IR and ConFF_Out back from the datapath.
- Runs fetch, then a per-opcode microsequence, then returns to fetch.

Parameters:
- MEM_WAIT, 1: cycles Read or Write is held for one RAM access (≥1).
- ADD_CODE, 5'b00011: ALU CONTROL code used for address and PC arithmetic.

Ports:
- Clock  in  1  single clock, rising edge.
- Clear  in  1  reset, synchronous, active-low.
- IR  in  32  instruction register contents; opcode = IR[31:27].
- ConFF_Out  in  1  branch condition result from the datapath.
- Stop  in  1  request to halt at the next instruction boundary.
- Run  out  1  high while executing; low in RESET/HALT.
- Clear_Out  out  1  active-high clear to the datapath.
- CONTROL  out  5  ALU operation code.
- IncPC, Read, Write  out  1 each  PC increment and memory strobes.
- PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, C_Out, InPort_Out  out  1 each  bus drivers.
- PC_In, MDR_In, MAR_In, IR_In, Y_In, ZHI_In, ZLO_In, HI_In, LO_In, InPort_In, OutPort_In, Con_In  out  1 each  latch enables.
- G_RA, G_RB, G_RC, R_In, R_Out, BA_Out  out  1 each  register select/encode controls.

Behaviour:
- State is {phase ∈ RESET, FETCH, EXEC, HALT; step counter 0..7; wait counter for MEM_WAIT}. Outputs decode combinationally from the registered state plus IR[31:27]. Every strobe not listed for a step is 0.
- Clear low at a rising edge: state becomes RESET, whatever the current step (this includes mid-instruction and mid-memory-wait). RESET outputs are Clear_Out=1, Run=0, all others 0. The first edge with Clear high moves RESET to FETCH step 0.
- InPort_In is 1 in every state except RESET.
- Fetch sequence:
  - F0: PC_Out, MAR_In, IncPC. If Stop=1 on entry, go to HALT instead.
  - F1: Read, MDR_In, held MEM_WAIT cycles.
  - F2: MDR_Out, IR_In.
  - EXEC T3 begins the next cycle; IR is valid from T3 onward.
- R-type ops (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011):
  - T3: G_RB, R_Out, Y_In.
  - T4: G_RC, R_Out, ZLO_In, CONTROL=opcode.
  - T5: ZLO_Out, G_RA, R_In.
- Immediate ops (addi 01100, andi 01101, ori 01110): T3 as R-type. T4: C_Out, ZLO_In, CONTROL = 00011, 00101 or 00110 respectively. T5 as R-type.
- neg 10001 / not 10010:
  - T3: G_RB, R_Out, ZLO_In, CONTROL=opcode.
  - T4: ZLO_Out, G_RA, R_In.
- mul 10000 / div 01111:
  - T3: G_RA, R_Out, Y_In.
  - T4: G_RB, R_Out, ZHI_In, ZLO_In, CONTROL=opcode.
  - T5: ZLO_Out, LO_In.
  - T6: ZHI_Out, HI_In.
- ld 00000, ldi 00001, st 00010 share an address sequence:
  - T3: G_RB, R_Out, BA_Out, Y_In.
  - T4: C_Out, ZLO_In, CONTROL=ADD_CODE.
  - ldi ends at T5: ZLO_Out, G_RA, R_In.
  - ld and st continue with T5: ZLO_Out, MAR_In.
  - ld: T6 Read, MDR_In held MEM_WAIT cycles; T7 MDR_Out, G_RA, R_In.
  - st: T6 G_RA, R_Out, MDR_In with Read=0; T7 Write held MEM_WAIT cycles.
- Branch, br 10011:
  - T3: G_RA, R_Out, Con_In.
  - T4: PC_Out, Y_In.
  - T5: C_Out, ZLO_In, CONTROL=ADD_CODE.
  - T6: ZLO_Out and PC_In, asserted only if ConFF_Out=1 in T6. T6 is always spent; not-taken branches idle that cycle.
- Jumps:
  - jr 10100: T3 G_RA, R_Out, PC_In.
  - jal 10101: T3 PC_Out, G_RB, R_In; T4 G_RA, R_Out, PC_In. The assembler encodes the link register in the rb field.
- Single-step ops:
  - in 10110: T3 InPort_Out, G_RA, R_In.
  - out 10111: T3 G_RA, R_Out, OutPort_In.
  - mfhi 11000: T3 HI_Out, G_RA, R_In.
  - mflo 11001: T3 LO_Out, G_RA, R_In.
- nop 11010 and opcodes 11100–11111: no EXEC strobes; return to F0.
- halt 11011: go to HALT. HALT has Run=0 and all strobes 0, and is left only via Clear.
- Each sequence returns to F0 on the edge after its last step.
- A memory wait counts down while the step is frozen; strobes stay constant for the whole wait.
- Exactly one bus driver is active per cycle, or none.

Decomposition:
- Shared package src_ctrl_pkg: 5-bit opcode constants, the phase enum, step-width constant.
- One sub-module, src_ctrl_decode: purely combinational mapping of (phase, step, opcode, ConFF_Out) to the strobe vector. The top holds the state and wait registers.

Test Plan:
- Fetch timing: Clear low 2 cycles then high, MEM_WAIT=1 → Clear_Out=1 in RESET; F0 shows PC_Out+MAR_In+IncPC; F1 shows Read+MDR_In for 1 cycle; F2 shows MDR_Out+IR_In; Run=1 from F0.
- add: IR=0x18000000|fields → T3 Y_In, T4 CONTROL=00011 with ZLO_In, T5 R_In; next cycle is F0 (6 cycles total).
- ld with MEM_WAIT=3 → T6 holds Read+MDR_In for exactly 3 cycles; T7 asserts R_In with MDR_Out. st → MAR_In at T5, Write high for 3 cycles at T7, Read never high in EXEC.
- br: ConFF_Out=1 at T6 → PC_In+ZLO_Out in T6. ConFF_Out=0 → no PC_In; F0 still follows T6.
- halt, and Stop=1 during an instruction → halt enters HALT with Run=0 held for 20 cycles. With Stop, the current instruction completes and HALT is entered at the F0 boundary.
- Clear low during the ld T6 wait → RESET next edge with Write=Read=0. Release → F0 fetch restarts.
